// File: rtl/neuron_pkg.sv
// Shared definitions for the neuron controller: FSM state encoding and the
// default in-to-out register depth of the attached neuron.
package neuron_pkg;

    localparam int LATENCY_DEFAULT = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_LFLUSH = 3'd2,
        ST_RUN    = 3'd3,
        ST_RESULT = 3'd4
    } state_t;

endpackage

// File: rtl/neuron_ctrl.sv
// Controller that streams weight words into a neuron, launches one sample at a
// time, waits out the neuron pipeline and hands back the registered decision.
module neuron_ctrl
    import neuron_pkg::*;
#(
    parameter int SIZE      = 8,
    parameter int ADDR_SIZE = 3,
    parameter int LATENCY   = LATENCY_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 w_valid,
    output logic                 w_ready,
    input  logic [7:0]           w_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [SIZE-1:0]      s_data,
    output logic                 r_valid,
    input  logic                 r_ready,
    output logic                 r_data,
    output logic [SIZE-1:0]      n_in,
    output logic [7:0]           n_set_weight,
    output logic [ADDR_SIZE-1:0] n_set_addr,
    output logic                 n_swr,
    input  logic                 n_out,
    output logic                 busy
);

    localparam int CNT_W = $clog2(LATENCY + 2);
    localparam logic [ADDR_SIZE-1:0] LAST_WORD = ADDR_SIZE'(SIZE - 1);
    localparam logic [CNT_W-1:0]     LAT_LAST  = CNT_W'(LATENCY);

    state_t                 state_r;
    state_t                 next_state_s;
    logic [ADDR_SIZE-1:0]   word_cnt_r;
    logic [CNT_W-1:0]       lat_cnt_r;
    logic                   w_fire_s;
    logic                   s_fire_s;
    logic                   last_word_s;
    logic                   run_done_s;

    assign w_fire_s    = w_valid && w_ready;
    assign s_fire_s    = s_valid && s_ready;
    assign last_word_s = (word_cnt_r == LAST_WORD);
    assign run_done_s  = (state_r == ST_RUN) && (lat_cnt_r == LAT_LAST);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode and handshake readies; a weight word beats a sample in IDLE.
    always_comb begin
        next_state_s = state_r;
        w_ready      = 1'b0;
        s_ready      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                w_ready = 1'b1;
                s_ready = !w_valid;
                if (w_valid) begin
                    if (last_word_s) begin
                        next_state_s = ST_LFLUSH;
                    end else begin
                        next_state_s = ST_LOAD;
                    end
                end else if (s_valid) begin
                    next_state_s = ST_RUN;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                w_ready = 1'b1;
                if (w_valid && last_word_s) begin
                    next_state_s = ST_LFLUSH;
                end else begin
                    next_state_s = ST_LOAD;
                end
            end
            ST_LFLUSH: begin
                next_state_s = ST_IDLE;
            end
            ST_RUN: begin
                if (run_done_s) begin
                    next_state_s = ST_RESULT;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_RESULT: begin
                if (r_ready) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_RESULT;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Weight write port: each accepted word is presented to the neuron one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_cnt_r   <= '0;
            n_swr        <= 1'b0;
            n_set_addr   <= '0;
            n_set_weight <= 8'd0;
        end else begin
            n_swr <= w_fire_s;
            if (w_fire_s) begin
                n_set_addr   <= word_cnt_r;
                n_set_weight <= w_data;
                if (last_word_s) begin
                    word_cnt_r <= '0;
                end else begin
                    word_cnt_r <= word_cnt_r + ADDR_SIZE'(1);
                end
            end else begin
                word_cnt_r <= word_cnt_r;
            end
        end
    end

    // Sample launch, pipeline wait and result capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_in      <= '0;
            lat_cnt_r <= '0;
            r_valid   <= 1'b0;
            r_data    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            busy <= (next_state_s != ST_IDLE);
            if (s_fire_s) begin
                n_in      <= s_data;
                lat_cnt_r <= '0;
            end else if (state_r == ST_RUN) begin
                lat_cnt_r <= lat_cnt_r + CNT_W'(1);
            end else begin
                lat_cnt_r <= lat_cnt_r;
            end
            if (run_done_s) begin
                r_valid <= 1'b1;
                r_data  <= n_out;
            end else if ((state_r == ST_RESULT) && r_ready) begin
                r_valid <= 1'b0;
            end else begin
                r_valid <= r_valid;
            end
        end
    end

endmodule

// File: tb/tb_neuron_ctrl.sv
// Bench for neuron_ctrl wired to a behavioural neuron; a scoreboard checks
// weight writes and decisions against a plain arithmetic reference model.
module tb_neuron_ctrl;
    import neuron_pkg::*;

    localparam int SIZE      = 8;
    localparam int ADDR_SIZE = 3;
    localparam int LAT       = LATENCY_DEFAULT;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 w_valid = 1'b0;
    logic                 w_ready;
    logic [7:0]           w_data = 8'd0;
    logic                 s_valid = 1'b0;
    logic                 s_ready;
    logic [SIZE-1:0]      s_data = '0;
    logic                 r_valid;
    logic                 r_ready = 1'b1;
    logic                 r_data;
    logic [SIZE-1:0]      n_in;
    logic [7:0]           n_set_weight;
    logic [ADDR_SIZE-1:0] n_set_addr;
    logic                 n_swr;
    logic                 n_out;
    logic                 busy;

    int cyc = 0;
    int chk_cnt = 0;
    int pass_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    neuron_ctrl #(.SIZE(SIZE), .ADDR_SIZE(ADDR_SIZE), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data),
        .n_in(n_in), .n_set_weight(n_set_weight), .n_set_addr(n_set_addr),
        .n_swr(n_swr), .n_out(n_out), .busy(busy)
    );

    // Behavioural neuron: weight RAM, 8-bit wrapped dot product, LAT-deep pipe.
    logic [7:0] nw [SIZE];
    logic       pipe [LAT];
    assign n_out = pipe[LAT-1];

    function automatic logic neuron_fire(input logic [SIZE-1:0] x);
        logic [7:0] acc;
        acc = 8'd0;
        for (int i = 0; i < SIZE; i++) if (x[i]) acc = acc + nw[i];
        return acc > 8'd128;
    endfunction

    initial begin
        nw = '{8'd234, 8'd6, 8'd1, 8'd2, 8'd42, 8'd31, 8'd1, 8'd10};
        for (int k = 0; k < LAT; k++) pipe[k] = 1'b0;
        forever begin
            @(posedge clk);
            if (n_swr) nw[n_set_addr] <= n_set_weight;
            pipe[0] <= neuron_fire(n_in);
            for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
        end
    end

    // Reference model: weights as integers, decision from the plain sum modulo 256.
    int ref_w [SIZE];
    int widx;

    function automatic bit model_decide(input logic [SIZE-1:0] x);
        int total;
        total = 0;
        for (int i = 0; i < SIZE; i++) if (x[i]) total += ref_w[i];
        return (total % 256) > 128;
    endfunction

    typedef struct {
        logic [7:0]           data;
        logic [ADDR_SIZE-1:0] addr;
        int                   cyc;
    } wr_t;
    typedef struct {
        bit              dec;
        logic [SIZE-1:0] x;
        int              cyc;
    } res_t;
    wr_t  wq[$];
    res_t sq[$];

    task automatic check(input string name, input longint act, input longint exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, required %0d", name, act, exp);
    endtask

    task automatic fail(input string name);
        chk_cnt++;
        $display("FAIL %s: got no event, required one", name);
    endtask

    initial begin : mon_writes
        wr_t e;
        forever begin
            @(negedge clk);
            if (!rst && n_swr) begin
                if (wq.size() == 0) begin
                    chk_cnt++;
                    $display("FAIL unexpected_write: got n_swr=1 addr %0d, required none", n_set_addr);
                end else begin
                    e = wq.pop_front();
                    check("wr_addr", n_set_addr, e.addr);
                    check("wr_data", n_set_weight, e.data);
                    check("wr_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin : mon_results
        res_t e;
        bit   prev_rv;
        prev_rv = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && r_valid && !prev_rv) begin
                if (sq.size() == 0) begin
                    chk_cnt++;
                    $display("FAIL unexpected_result: got r_valid=1, required none");
                end else begin
                    e = sq.pop_front();
                    check("r_data", r_data, e.dec);
                    check("r_cycle", cyc, e.cyc);
                    check("n_in", n_in, e.x);
                end
            end
            prev_rv = r_valid;
        end
    end

    task automatic send_word(input logic [7:0] d, input int gap);
        int n;
        w_valid = 1'b0;
        repeat (gap) @(negedge clk);
        w_valid = 1'b1;
        w_data  = d;
        n = 0;
        forever begin
            #1;
            if (w_ready) begin
                wq.push_back('{data: d, addr: ADDR_SIZE'(widx), cyc: cyc + 1});
                ref_w[widx] = d;
                widx = (widx + 1) % SIZE;
                @(negedge clk);
                break;
            end
            @(negedge clk);
            n++;
            if (n > 50) begin
                fail("w_accept_timeout");
                break;
            end
        end
        w_valid = 1'b0;
    endtask

    task automatic send_sample(input logic [SIZE-1:0] x, output int acc);
        int n;
        acc = 0;
        s_valid = 1'b1;
        s_data  = x;
        n = 0;
        forever begin
            #1;
            if (s_ready) begin
                acc = cyc + 1;
                sq.push_back('{dec: model_decide(x), x: x, cyc: cyc + 1 + LAT + 1});
                @(negedge clk);
                break;
            end
            @(negedge clk);
            n++;
            if (n > 50) begin
                fail("s_accept_timeout");
                break;
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic run_sample(input logic [SIZE-1:0] x, input int hold, output int acc);
        int n;
        bit exp_d;
        exp_d   = model_decide(x);
        r_ready = (hold == 0);
        send_sample(x, acc);
        n = 0;
        while (!r_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!r_valid) fail("result_timeout");
        for (int i = 0; i < hold; i++) begin
            #1;
            check("hold_r_valid", r_valid, 1);
            check("hold_r_data", r_data, exp_d);
            check("hold_w_ready", w_ready, 0);
            check("hold_s_ready", s_ready, 0);
            @(negedge clk);
        end
        r_ready = 1'b1;
        n = 0;
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (busy) fail("idle_timeout");
    endtask

    task automatic check_reset();
        check("rst_n_in", n_in, 0);
        check("rst_n_set_weight", n_set_weight, 0);
        check("rst_n_set_addr", n_set_addr, 0);
        check("rst_n_swr", n_swr, 0);
        check("rst_r_valid", r_valid, 0);
        check("rst_r_data", r_data, 0);
        check("rst_busy", busy, 0);
        check("rst_w_ready", w_ready, 1);
        check("rst_s_ready", s_ready, 1);
    endtask

    task automatic do_reset();
        w_valid = 1'b0;
        s_valid = 1'b0;
        #2 rst = 1'b1;
        sq.delete();
        wq.delete();
        widx = 0;
        repeat (2) @(negedge clk);
        #1 check_reset();
        #1 rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin : stimulus
        int a;
        int b;
        ref_w = '{234, 6, 1, 2, 42, 31, 1, 10};
        widx  = 0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        #1 check_reset();
        #1 rst = 1'b0;
        @(negedge clk);

        run_sample(8'h01, 0, a);
        run_sample(8'hFF, 0, b);
        check("sample_period", b - a, LAT + 3);

        for (int i = 0; i < SIZE; i++) send_word(8'h10, 0);
        run_sample(8'hFF, 0, a);
        for (int i = 0; i < SIZE; i++) send_word(8'h11, i % 2);
        run_sample(8'hFF, 0, a);

        s_valid = 1'b1;
        s_data  = 8'hFF;
        w_valid = 1'b1;
        w_data  = 8'h20;
        #1 check("simul_s_ready", s_ready, 0);
        for (int i = 0; i < SIZE; i++) send_word(8'(8'h20 + 8'(i * 3)), 0);
        run_sample(8'hFF, 0, a);

        run_sample(8'h5A, 5, a);

        for (int i = 0; i < 3; i++) send_word(8'(8'hC0 + 8'(i)), 0);
        @(negedge clk);
        do_reset();
        for (int i = 0; i < SIZE; i++) send_word(8'($urandom_range(0, 255)), 0);
        run_sample(8'($urandom_range(0, 255)), 0, a);

        r_ready = 1'b1;
        send_sample(8'hFF, a);
        @(negedge clk);
        do_reset();
        repeat (8) @(negedge clk);
        #1 check("run_rst_r_valid", r_valid, 0);
        @(negedge clk);

        r_ready = 1'b0;
        send_sample(8'h0F, a);
        repeat (LAT + 2) @(negedge clk);
        do_reset();
        r_ready = 1'b1;

        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                for (int i = 0; i < SIZE; i++)
                    send_word(8'($urandom_range(0, 255)), int'($urandom_range(0, 2)));
            end else begin
                run_sample(8'($urandom_range(0, 255)),
                           ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : 0, a);
            end
        end

        repeat (4) @(negedge clk);
        check("sq_drained", sq.size(), 0);
        check("wq_drained", wq.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/neuron_ctrl.md
NEURON_CTRL -- requirements
Module: neuron_ctrl

Interface
REQ-001 SHALL have parameter SIZE, default 8, number of neuron inputs/weights.
REQ-002 SHALL have parameter ADDR_SIZE, default 3, weight address width (2^ADDR_SIZE >= SIZE).
REQ-003 SHALL have parameter LATENCY, default 3, neuron in-to-out register depth.
REQ-004 SHALL provide one clock; reset is asynchronous and active-high:
 clk  in  1  rising-edge clock
 rst  in  1  asynchronous active-high reset
 w_valid  in  1  weight word offered
 w_ready  out  1  weight word accepted when w_valid&&w_ready
 w_data  in  8  weight value
 s_valid  in  1  sample offered
 s_ready  out  1  sample accepted when s_valid&&s_ready
 s_data  in  SIZE  binary input vector
 r_valid  out  1  classification result available
 r_ready  in  1  result consumed when r_valid&&r_ready
 r_data  out  1  neuron decision
 n_in  out  SIZE  to neuron in
 n_set_weight  out  8  to neuron set_weight
 n_set_addr  out  ADDR_SIZE  to neuron set_addr
 n_swr  out  1  to neuron swr
 n_out  in  1  from neuron out
 busy  out  1  high in any state except IDLE

Function
REQ-005 SHALL implement states IDLE, LOAD, LFLUSH, RUN, RESULT.
REQ-006 IDLE: w_ready=1, s_ready=!w_valid; weight word wins if w_valid and s_valid are simultaneous.
REQ-007 IDLE + weight accept -> LOAD; word index 0 written; word counter becomes 1.
REQ-008 Each accepted word SHALL be registered: following cycle n_swr=1, n_set_addr=word index, n_set_weight=w_data.
REQ-009 LOAD: w_ready=1, s_ready=0; accept one word per cycle; gaps (w_valid=0) drive n_swr=0 and do not advance counter.
REQ-010 Accept of word SIZE-1 -> LFLUSH; counter wraps to 0; w_ready=0 in LFLUSH.
REQ-011 LFLUSH lasts exactly one cycle (final write driven) -> IDLE.
REQ-012 IDLE + sample accept -> RUN; n_in registers s_data at accept edge E0 and holds until next sample accept.
REQ-013 n_swr SHALL be 0 in IDLE, RUN and RESULT.
REQ-014 RUN SHALL count LATENCY+1 edges; at edge E0+LATENCY+1 capture n_out into r_data and -> RESULT.
REQ-015 RESULT: r_valid=1, r_data stable, w_ready=s_ready=0; r_valid&&r_ready -> IDLE next edge.
REQ-016 Back-to-back: sample/weight accept possible the cycle after return to IDLE; minimum sample-to-sample period LATENCY+3 cycles.
REQ-017 Neuron decision SHALL be 1 iff 8-bit wrapped sum of weight[i]*in[i] > 128; controller passes n_out unmodified.

Reset
REQ-018 rst SHALL force IDLE, counters 0, n_in=0, n_set_weight=0, n_set_addr=0, n_swr=0, r_valid=0, r_data=0, busy=0.
REQ-019 rst mid-LOAD SHALL abandon load; already-written neuron weights remain; next load restarts at address 0.
REQ-020 rst mid-RUN/RESULT SHALL discard the pending result.

Structure
REQ-021 State enum and LATENCY default SHALL live in shared package neuron_pkg.
REQ-022 No sub-module; the neuron is instantiated beside neuron_ctrl by the parent, ports wired one-to-one.

Verification (bench: neuron_ctrl + neuron, power-on weights 234,6,1,2,42,31,1,10)
REQ-023 Sample 8'b00000001, r_ready=1 -> r_valid at E0+4, r_data=1 (sum 234).
REQ-024 Sample 8'hFF -> r_data=0 (sum 327 wraps to 71).
REQ-025 Load 8 words 8'h10 then sample 8'hFF -> r_data=0 (sum exactly 128); reload 8'h11, same sample -> r_data=1 (136).
REQ-026 w_valid and s_valid asserted together in IDLE -> weight accepted, s_ready=0 until LFLUSH->IDLE; sample then scored with new weights.
REQ-027 Hold r_ready=0 for 5 cycles in RESULT -> r_valid/r_data stable, s_ready=0 and w_ready=0 throughout.
REQ-028 rst after 3 of 8 words -> all outputs at reset values; new 8-word load writes addresses 0..7 in order.
